down_timer: RTL and testbench
=============================

# down_timer

Loadable down-counting timer with terminal-count pulse and optional auto-reload. It is the decrementing counterpart of the team's up counter. It is loaded with a start value, counts down one step per enabled cycle, and signals expiry with a one-cycle `tc` pulse. It sits beside the up counter as the team's interval/timeout generator.

## Interface

Parameters:
- `WIDTH`, default 4: counter width in bits; supported range is 2 to 16.

Ports:
- `clk`, input, 1 bit: single clock; all state changes on the rising edge.
- `res`, input, 1 bit: reset, **synchronous and active-low**; sampled on the rising edge of `clk`.
- `load`, input, 1 bit: load strobe, sampled at the clock edge.
- `load_val`, input, WIDTH bits: start value, captured when `load`=1.
- `reload`, input, 1 bit: auto-reload mode request, captured together with `load`.
- `en`, input, 1 bit: count enable.
- `out`, output, WIDTH bits: current count (registered).
- `busy`, output, 1 bit: 1 while in RUN (registered).
- `tc`, output, 1 bit: terminal-count pulse, one cycle wide (registered).

## Operation

- Internal state:
  - FSM state: IDLE or RUN.
  - `period_q` (WIDTH bits): latched `load_val`.
  - `mode_q` (1 bit): latched `reload`.
- Reset (`res`=0 at an edge):
  - State goes to IDLE.
  - `out`=0, `busy`=0, `tc`=0, `period_q`=0, `mode_q`=0.
  - Reset overrides every other input, including in the middle of a count.
- `tc` defaults to 0 every cycle and is 1 only on the transitions marked below.
- Priority, highest first: reset > `load` > `en`.
- IDLE:
  - `load`=1 and `load_val`≠0:
    - `out`<=`load_val`, `period_q`<=`load_val`, `mode_q`<=`reload`.
    - Go to RUN.
  - `load`=1 and `load_val`=0:
    - `out`<=0, `period_q`<=0, `mode_q`<=`reload`.
    - Stay in IDLE; no `tc`.
  - Otherwise: hold. `en` is ignored in IDLE.
- RUN:
  - `load`=1: restart exactly as in IDLE. The current count is discarded and no `tc` is produced for it.
  - `en`=0: hold `out`.
  - `en`=1 and `out`>1: `out`<=`out`-1.
  - `en`=1, `out`=1, `mode_q`=0:
    - `out`<=0, `tc`<=1.
    - Go to IDLE.
  - `en`=1, `out`=1, `mode_q`=1:
    - `out`<=`period_q`, `tc`<=1.
    - Stay in RUN.
    - `out` never shows 0 in this mode.
- `busy` equals (state==RUN), registered with the state.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH.
  - In RUN, `out` stays in the range 1..`period_q`, so it never underflows.
  - `load_val`=2^WIDTH-1 is legal and gives the maximum period.

## Timing

- Load latency is one edge: `load` sampled at edge k gives `out`=`load_val` and `busy`=1 after edge k.
- One-shot mode, `en` held high from edge k+1: `out` steps N-1, …, 1, 0. `tc`=1 and `busy`=0 appear together after edge k+N.
- Auto-reload mode: one `tc` per N enabled cycles. `tc` is coincident with `out`=N.
- Gated `en` stretches the interval: `tc` follows the N-th enabled cycle after the load, not the N-th clock.
- `tc` is never wider than one cycle in one-shot mode. In auto-reload mode with N=1, `tc` is held high continuously while `en`=1.
- `load` and terminal count on the same edge: the load wins, and no `tc` is produced.
- Reset on the same edge as a terminal count: `tc`=0.

## Test plan

- **Reset:** drive `res`=0 for 2 cycles with `load`=1, `load_val`=7. Required: `out`=0, `busy`=0, `tc`=0 throughout.
- **One-shot, N=5, `en`=1:** load 5. Required: `out` reads 5, 4, 3, 2, 1, 0. `tc`=1 on the cycle `out`=0. `busy` drops on that same cycle. `tc`=0 afterwards.
- **Auto-reload, N=3, `en`=1 for 10 cycles:** required `out` sequence 3, 2, 1, 3, 2, 1, 3, 2, 1, 3. `tc` is high on each cycle where `out` returns to 3 after 1. `busy` stays 1.
- **Gated enable:** load 4, then toggle `en` 1, 0, 1, 0, …. Required: `out` decrements only after `en`=1 cycles. `tc` appears after the 4th enabled cycle (about 8 clocks).
- **Restart and zero load:**
  - Load 6, then load 2 when `out`=3. Required: `out`=2 next, no `tc` for the abandoned count, `tc` two enabled cycles later.
  - Load 0. Required: stays in IDLE, `tc`=0.
- **Mid-run reset and maximum value (`WIDTH`=4):**
  - Load 15 with `reload`=1, then assert `res`=0 when `out`=9. Required: next `out`=0, `busy`=0.
  - Reload 15 after reset. Required: `tc` every 15 enabled cycles.

Source files
------------

// File: rtl/down_timer_if.sv
// Control/status bundle for the down_timer: load/reload/enable strobes in,
// current count with busy and terminal-count flags out.
interface down_timer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             reload;
    logic             en;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             tc;

    modport master (
        output load, load_val, reload, en,
        input  out, busy, tc
    );

    modport slave (
        input  load, load_val, reload, en,
        output out, busy, tc
    );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counting timer: one-cycle tc pulse on expiry, optional
// auto-reload of the latched period.
module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        res,
    down_timer_if.slave tif
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             tc_q, tc_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        mode_d   = mode_q;
        tc_d     = 1'b0;

        if (tif.load) begin
            // A load restarts from either state; a zero period parks in IDLE.
            cnt_d    = tif.load_val;
            period_d = tif.load_val;
            mode_d   = tif.reload;
            state_d  = (tif.load_val != '0) ? RUN : IDLE;
        end else if (state_q == RUN && tif.en) begin
            if (cnt_q > WIDTH'(1)) begin
                cnt_d = cnt_q - WIDTH'(1);
            end else begin
                tc_d = 1'b1;
                if (mode_q) begin
                    cnt_d = period_q;
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            tc_q     <= tc_d;
        end
    end

    assign tif.out  = cnt_q;
    assign tif.busy = busy_q;
    assign tif.tc   = tc_q;
endmodule

// File: tb/tb_down_timer.sv
// Bench for down_timer: directed scenarios plus randomized traffic, all
// checked against an enabled-cycle-count model of the timer.
module tb_down_timer;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    down_timer_if #(.WIDTH(WIDTH)) tif();

    down_timer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .res (res),
        .tif (tif.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: period n, enabled cycles k since the last load, active flag.
    int m_n, m_k;
    bit m_mode, m_active, m_tc;

    function automatic logic [WIDTH-1:0] exp_out();
        int v;
        v = m_active ? (m_n - (m_k % m_n)) : 0;
        return WIDTH'(v);
    endfunction

    task automatic step(input bit r, input bit ld, input int lv, input bit rl, input bit e);
        int lvm;
        lvm = lv & ((1 << WIDTH) - 1);
        res          = r;
        tif.load     = ld;
        tif.load_val = WIDTH'(lvm);
        tif.reload   = rl;
        tif.en       = e;
        @(posedge clk);
        if (!r) begin
            m_n = 0; m_k = 0; m_mode = 0; m_active = 0; m_tc = 0;
        end else begin
            m_tc = 0;
            if (ld) begin
                m_n = lvm; m_mode = rl; m_k = 0; m_active = (lvm != 0);
            end else if (m_active && e) begin
                m_k++;
                if (m_k % m_n == 0) m_tc = 1;
                if (!m_mode && m_k == m_n) m_active = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 7, 0, 0);
            n_cmp++;
            if (tif.out !== '0 || tif.busy !== 1'b0 || tif.tc !== 1'b0) begin
                n_bad++;
                $display("FAIL reset out=%0d busy=%b tc=%b required 0 0 0", tif.out, tif.busy, tif.tc);
            end
        end
    endtask

    task automatic test_oneshot();
        int seq [6] = '{5, 4, 3, 2, 1, 0};
        for (int i = 0; i < 7; i++) begin
            if (i == 0) step(1, 1, 5, 0, 0);
            else        step(1, 0, 0, 0, 1);
            n_cmp++;
            if (i < 6 && (tif.out !== WIDTH'(seq[i]) || tif.busy !== (i < 5) || tif.tc !== (i == 5))) begin
                n_bad++;
                $display("FAIL oneshot[%0d] out=%0d busy=%b tc=%b required %0d %b %b",
                         i, tif.out, tif.busy, tif.tc, seq[i], i < 5, i == 5);
            end
            if (i == 6 && (tif.out !== '0 || tif.busy !== 1'b0 || tif.tc !== 1'b0)) begin
                n_bad++;
                $display("FAIL oneshot_after out=%0d busy=%b tc=%b required 0 0 0", tif.out, tif.busy, tif.tc);
            end
        end
    endtask

    task automatic test_autoreload();
        int seq [10] = '{3, 2, 1, 3, 2, 1, 3, 2, 1, 3};
        for (int i = 0; i < 10; i++) begin
            if (i == 0) step(1, 1, 3, 1, 0);
            else        step(1, 0, 0, 0, 1);
            n_cmp++;
            if (tif.out !== WIDTH'(seq[i]) || tif.busy !== 1'b1 || tif.tc !== (i > 0 && i % 3 == 0)) begin
                n_bad++;
                $display("FAIL autoreload[%0d] out=%0d busy=%b tc=%b required %0d 1 %b",
                         i, tif.out, tif.busy, tif.tc, seq[i], i > 0 && i % 3 == 0);
            end
        end
    endtask

    task automatic test_gated();
        logic [WIDTH-1:0] eo;
        step(1, 1, 4, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0, 0, (i % 2 == 0));
            eo = exp_out();
            n_cmp++;
            if (tif.tc !== (i == 6) || tif.out !== eo || tif.busy !== m_active) begin
                n_bad++;
                $display("FAIL gated[%0d] out=%0d busy=%b tc=%b required %0d %b %b",
                         i, tif.out, tif.busy, tif.tc, eo, m_active, i == 6);
            end
        end
    endtask

    task automatic test_restart();
        step(1, 1, 6, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
        step(1, 1, 2, 0, 1);
        n_cmp++;
        if (tif.out !== WIDTH'(2) || tif.tc !== 1'b0 || tif.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_load out=%0d tc=%b busy=%b required 2 0 1", tif.out, tif.tc, tif.busy);
        end
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        n_cmp++;
        if (tif.out !== '0 || tif.tc !== 1'b1 || tif.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_tc out=%0d tc=%b busy=%b required 0 1 0", tif.out, tif.tc, tif.busy);
        end
        // Load coinciding with terminal count: the load wins, no tc.
        step(1, 1, 1, 0, 0);
        step(1, 1, 3, 0, 1);
        n_cmp++;
        if (tif.out !== WIDTH'(3) || tif.tc !== 1'b0 || tif.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL load_vs_tc out=%0d tc=%b busy=%b required 3 0 1", tif.out, tif.tc, tif.busy);
        end
    endtask

    task automatic test_zero_load();
        step(1, 1, 0, 1, 1);
        step(1, 0, 0, 0, 1);
        n_cmp++;
        if (tif.out !== '0 || tif.busy !== 1'b0 || tif.tc !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_load out=%0d busy=%b tc=%b required 0 0 0", tif.out, tif.busy, tif.tc);
        end
    endtask

    task automatic test_midrun_reset();
        step(1, 1, 15, 1, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1);
        n_cmp++;
        if (tif.out !== WIDTH'(9)) begin
            n_bad++;
            $display("FAIL midrun_pre out=%0d required 9", tif.out);
        end
        step(0, 0, 0, 0, 1);
        n_cmp++;
        if (tif.out !== '0 || tif.busy !== 1'b0 || tif.tc !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_reset out=%0d busy=%b tc=%b required 0 0 0", tif.out, tif.busy, tif.tc);
        end
        // Reset on the terminal-count edge suppresses tc.
        step(1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        n_cmp++;
        if (tif.tc !== 1'b0 || tif.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_vs_tc tc=%b busy=%b required 0 0", tif.tc, tif.busy);
        end
    endtask

    task automatic test_max_period();
        int tcs = 0;
        step(1, 1, 15, 1, 0);
        for (int i = 0; i < 45; i++) begin
            step(1, 0, 0, 0, 1);
            if (tif.tc === 1'b1) tcs++;
            n_cmp++;
            if (tif.tc !== (i % 15 == 14) || tif.busy !== 1'b1 || tif.out === '0) begin
                n_bad++;
                $display("FAIL max_period[%0d] out=%0d busy=%b tc=%b required tc=%b busy=1 out!=0",
                         i, tif.out, tif.busy, tif.tc, i % 15 == 14);
            end
        end
        n_cmp++;
        if (tcs != 3) begin
            n_bad++;
            $display("FAIL max_period_count tcs=%0d required 3", tcs);
        end
    endtask

    task automatic test_n1_reload();
        step(1, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 1);
            n_cmp++;
            if (tif.tc !== 1'b1 || tif.out !== WIDTH'(1) || tif.busy !== 1'b1) begin
                n_bad++;
                $display("FAIL n1_reload[%0d] out=%0d busy=%b tc=%b required 1 1 1", i, tif.out, tif.busy, tif.tc);
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] eo;
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 40) != 0), ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, (1 << WIDTH) - 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0));
            eo = exp_out();
            n_cmp++;
            if (tif.out !== eo || tif.busy !== m_active || tif.tc !== m_tc) begin
                n_bad++;
                $display("FAIL random[%0d] out=%0d busy=%b tc=%b required %0d %b %b",
                         i, tif.out, tif.busy, tif.tc, eo, m_active, m_tc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_gated();
        test_restart();
        test_zero_load();
        test_midrun_reset();
        test_max_period();
        test_n1_reload();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
